// File: rtl/zero_compress_32to16.sv
// Purpose: narrow 2*OUT_W-bit words to OUT_W-bit beats; a word with a zero upper half goes out as one compressed beat.
// Latency: first beat is valid one cycle after the word is accepted; full words take a second beat.
// Backpressure: out_ready low holds the current beat stable; in_ready is high only in IDLE and ignores out_ready.
module zero_compress_32to16 #(
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*OUT_W-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 out_compressed,
    output logic [CNT_W-1:0]     cnt_comp,
    output logic [CNT_W-1:0]     cnt_full
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t               state;
    logic [2*OUT_W-1:0]   word_reg;
    logic                 zflag;

    // Upper half of the incoming word is zero: the receiver can rebuild it by zero extension.
    logic                 in_upper_zero;
    assign in_upper_zero = (in_data[2*OUT_W-1:OUT_W] == '0);

    // Single FSM: captures the word, sequences beats, keeps statistics; all outputs are registered
    // so they depend only on state and word_reg and cannot glitch during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            word_reg       <= '0;
            zflag          <= 1'b0;
            cnt_comp       <= '0;
            cnt_full       <= '0;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_first      <= 1'b0;
            out_last       <= 1'b0;
            out_compressed <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is high in this state, so in_valid alone completes the handshake.
                    if (in_valid) begin
                        word_reg       <= in_data;
                        zflag          <= in_upper_zero;
                        state          <= SEND_LO;
                        in_ready       <= 1'b0;
                        out_valid      <= 1'b1;
                        out_data       <= in_data[OUT_W-1:0];
                        out_first      <= 1'b1;
                        out_last       <= in_upper_zero;
                        out_compressed <= in_upper_zero;
                    end
                end

                SEND_LO: begin
                    if (out_ready) begin
                        if (zflag) begin
                            // Compressed word finished with this single beat.
                            if (cnt_comp != CNT_MAX) begin
                                cnt_comp <= cnt_comp + CNT_ONE;
                            end
                            state          <= IDLE;
                            in_ready       <= 1'b1;
                            out_valid      <= 1'b0;
                            out_data       <= '0;
                            out_first      <= 1'b0;
                            out_last       <= 1'b0;
                            out_compressed <= 1'b0;
                        end else begin
                            // Low half delivered; present the upper half next.
                            state          <= SEND_HI;
                            out_data       <= word_reg[2*OUT_W-1:OUT_W];
                            out_first      <= 1'b0;
                            out_last       <= 1'b1;
                            out_compressed <= 1'b0;
                        end
                    end
                end

                SEND_HI: begin
                    if (out_ready) begin
                        if (cnt_full != CNT_MAX) begin
                            cnt_full <= cnt_full + CNT_ONE;
                        end
                        state          <= IDLE;
                        in_ready       <= 1'b1;
                        out_valid      <= 1'b0;
                        out_data       <= '0;
                        out_first      <= 1'b0;
                        out_last       <= 1'b0;
                        out_compressed <= 1'b0;
                    end
                end

                default: begin
                    // Unreachable encoding: fall back to a clean idle.
                    state          <= IDLE;
                    in_ready       <= 1'b1;
                    out_valid      <= 1'b0;
                    out_data       <= '0;
                    out_first      <= 1'b0;
                    out_last       <= 1'b0;
                    out_compressed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zero_compress_32to16.sv
// Purpose: randomized and directed stimulus against a beat-queue reference model of the narrowing block.
// Latency: model pushes beats on the accepting edge, so they are expected at the following cycle.
// Backpressure: random out_ready stalls; the model's head beat must stay presented until taken.
module tb_zero_compress_32to16;

    localparam int OUT_W = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready, in_ready4;
    logic [31:0] in_data;
    logic        out_valid, out_valid4;
    logic        out_ready;
    logic [15:0] out_data, out_data4;
    logic        out_first, out_first4;
    logic        out_last, out_last4;
    logic        out_compressed, out_compressed4;
    logic [15:0] cnt_comp, cnt_full;
    logic [3:0]  cnt_comp4, cnt_full4;

    zero_compress_32to16 #(.OUT_W(OUT_W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_last(out_last), .out_compressed(out_compressed),
        .cnt_comp(cnt_comp), .cnt_full(cnt_full)
    );

    zero_compress_32to16 #(.OUT_W(OUT_W), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_first(out_first4), .out_last(out_last4), .out_compressed(out_compressed4),
        .cnt_comp(cnt_comp4), .cnt_full(cnt_full4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dat;
        logic        first;
        logic        last;
        logic        comp;
    } beat_t;

    beat_t  q[$];
    int     m_comp, m_full;
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_comp = 0;
        m_full = 0;
    endtask

    // Compare both DUTs against the model state for the current cycle.
    task automatic check_all();
        logic        busy;
        beat_t       h;
        busy = (q.size() != 0);
        h = '{dat: 16'h0, first: 1'b0, last: 1'b0, comp: 1'b0};
        if (busy) h = q[0];
        chk("in_ready", 32'(in_ready), 32'(!busy));
        chk("out_valid", 32'(out_valid), 32'(busy));
        chk("out_data", 32'(out_data), 32'(h.dat));
        chk("out_first", 32'(out_first), 32'(h.first));
        chk("out_last", 32'(out_last), 32'(h.last));
        chk("out_comp", 32'(out_compressed), 32'(h.comp));
        chk("cnt_comp", 32'(cnt_comp), 32'(sat(m_comp, 65535)));
        chk("cnt_full", 32'(cnt_full), 32'(sat(m_full, 65535)));
        chk("in_ready4", 32'(in_ready4), 32'(!busy));
        chk("out_data4", 32'(out_data4), 32'(h.dat));
        chk("flags4", 32'({out_valid4, out_first4, out_last4, out_compressed4}),
            32'({busy, h.first, h.last, h.comp}));
        chk("cnt_comp4", 32'(cnt_comp4), 32'(sat(m_comp, 15)));
        chk("cnt_full4", 32'(cnt_full4), 32'(sat(m_full, 15)));
    endtask

    // One cycle: check at negedge, drive inputs, advance the model on the posedge handshakes.
    task automatic cycle(input logic iv, input logic [31:0] id, input logic ordy);
        logic acc_in, acc_out;
        @(negedge clk);
        check_all();
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        acc_in  = iv && (q.size() == 0);
        acc_out = ordy && (q.size() != 0);
        @(posedge clk);
        if (acc_out) begin
            if (q[0].last) begin
                if (q[0].comp) m_comp++;
                else m_full++;
            end
            void'(q.pop_front());
        end
        if (acc_in) begin
            if (id[31:16] == 16'h0) begin
                q.push_back('{dat: id[15:0], first: 1'b1, last: 1'b1, comp: 1'b1});
            end else begin
                q.push_back('{dat: id[15:0], first: 1'b1, last: 1'b0, comp: 1'b0});
                q.push_back('{dat: id[31:16], first: 1'b0, last: 1'b1, comp: 1'b0});
            end
        end
    endtask

    logic [31:0] pend;
    logic        have;
    logic        ivr;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset then idle.
        repeat (5) cycle(1'b0, 32'h0, 1'b0);

        // Reset in the middle of a full word: abandoned, no counter change.
        cycle(1'b1, 32'hFFFF0000, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);           // low beat taken, now sending the upper half
        @(negedge clk);
        check_all();
        chk("pre_rst_hi", 32'(out_data), 32'h0000FFFF);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 32'h00000007, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);

        // Directed: compressed, full, zero, boundary full, backpressured full.
        cycle(1'b1, 32'h0000BEEF, 1'b1);
        repeat (2) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h12345678, 1'b1);
        repeat (3) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h00000000, 1'b1);
        repeat (2) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h00010000, 1'b1);
        repeat (3) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'hCAFE0001, 1'b0);
        repeat (4) cycle(1'b1, 32'hDEADDEAD, 1'b0);   // ignored while busy
        repeat (3) cycle(1'b0, 32'h0, 1'b1);

        // Saturation on the 4-bit instance: back-to-back compressed words.
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 32'(i) & 32'h0000FFFF, 1'b1);
            cycle(1'b0, 32'h0, 1'b1);
        end
        cycle(1'b0, 32'h0, 1'b1);

        // Randomized traffic; upstream holds its word until accepted.
        have = 1'b0;
        pend = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            if (!have) begin
                pend = $urandom();
                if ($urandom_range(0, 1) == 0) pend[31:16] = 16'h0;
                have = ($urandom_range(0, 3) != 0);
            end
            ivr = have;
            if (have && q.size() == 0) have = 1'b0;
            cycle(ivr, pend, ($urandom_range(0, 3) != 0));
        end
        repeat (4) cycle(1'b0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zero_compress_32to16.md
Name: zero_compress_32to16

Overview:
- Narrowing counterpart of the datapath's 16-to-32 zero extension.
- Accepts 32-bit words over a valid/ready handshake and emits them as 16-bit halfword beats.
- A word whose upper half is zero goes out as one "compressed" beat, since the receiver can restore it by zero extension.
- Any other word goes out as two beats, low half first. Used ahead of halfword-wide storage and transfer paths.

Parameters:
- OUT_W, 16, output halfword width. Input width is 2*OUT_W.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word
- in_data  input  2*OUT_W  word to narrow
- out_valid  output  1  halfword beat valid
- out_ready  input  1  downstream accepts beat
- out_data  output  OUT_W  halfword beat
- out_first  output  1  beat is first of its word
- out_last  output  1  beat is last of its word
- out_compressed  output  1  word was sent as a single beat (upper half zero)
- cnt_comp  output  CNT_W  number of words completed as compressed
- cnt_full  output  CNT_W  number of words completed as two beats

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, word_reg=0, zflag=0, cnt_comp=0, cnt_full=0. Outputs are out_valid=0, in_ready=1, out_data=0, out_first=0, out_last=0, out_compressed=0.
- FSM states: IDLE, SEND_LO, SEND_HI.
- in_ready = (state==IDLE). It does not depend combinationally on out_ready.
- IDLE:
  - On in_valid&&in_ready: word_reg<=in_data; zflag<=(in_data[2*OUT_W-1:OUT_W]==0); state<=SEND_LO.
  - Otherwise hold.
- SEND_LO: out_valid=1, out_data=word_reg[OUT_W-1:0], out_first=1, out_last=zflag, out_compressed=zflag.
  - On out_ready with zflag=1: cnt_comp increments, state<=IDLE.
  - On out_ready with zflag=0: state<=SEND_HI.
- SEND_HI: out_valid=1, out_data=word_reg[2*OUT_W-1:OUT_W], out_first=0, out_last=1, out_compressed=0.
  - On out_ready: cnt_full increments, state<=IDLE.
- In IDLE all out_* data and flag outputs are 0.
- Out_* outputs are decoded from registered state and word_reg only. They stay stable while out_valid&&!out_ready, for any number of stall cycles.
- Latency: input accept edge to first beat valid is 1 cycle.
- Throughput: one compressed word per 2 cycles, one full word per 3 cycles, with out_ready held high.
- Value 0x00000000 is compressed: one beat, data 0x0000. Value 0x00010000 is full: beats 0x0000 then 0x0001.
- Counters saturate at all-ones and do not wrap. Each counter increments only on the accepting edge of a word's last beat.
- Reset mid-word: the word is abandoned and never appears. No counter increment. Reset has priority over every handshake.
- in_valid is ignored outside IDLE. Upstream must hold its data until in_ready.

Test Plan:
- Reset then idle: in_valid=0 for 5 cycles -> in_ready=1, out_valid=0, counters 0.
- Compressed word: send 0x0000BEEF with out_ready=1 -> one beat 0xBEEF with first=1, last=1, compressed=1. Returns to IDLE next cycle; cnt_comp=1.
- Full word: send 0x12345678 -> beat 0x5678 (first=1, last=0, compressed=0), then 0x1234 (first=0, last=1). cnt_full=1, in_ready low for 2 cycles.
- Backpressure: send 0xCAFE0001 with out_ready=0 for 4 cycles -> out_data holds 0x0001 steadily and in_ready stays 0. Release -> 0x0001, 0xCAFE delivered, then in_ready=1.
- Reset mid-word: rst pulsed while in SEND_HI for 0xFFFF0000 -> outputs return to reset values immediately. cnt_full is unchanged; the next word 0x00000007 is emitted correctly.
- Saturation (CNT_W=4 build): 17 compressed words -> cnt_comp=0xF and stays 0xF.
